// File: rtl/rob_commit_pkg.sv
// Shared widths and constants for the reorder-buffer commit slice.
package rob_commit_pkg;

    localparam int PcLength   = 31;
    localparam int DataLength = 31;
    localparam int RdLength   = 4;
    localparam int ROB_DEPTH  = 16;

    localparam logic [PcLength:0] Zero  = '0;
    localparam logic              True  = 1'b1;
    localparam logic              False = 1'b0;

endpackage

// File: rtl/rob_tag_match.sv
// Writeback tag CAM: compares the broadcast tag against every busy entry's PC.
module rob_tag_match
    import rob_commit_pkg::*;
#(
    parameter int DEPTH = ROB_DEPTH
) (
    input  logic [DEPTH-1:0]  busy_i,
    input  logic [PcLength:0] pc_i [DEPTH],
    input  logic [PcLength:0] wb_pc_i,
    output logic [DEPTH-1:0]  hit_o
);

    for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
        assign hit_o[i] = busy_i[i] && (pc_i[i] == wb_pc_i);
    end

endmodule

// File: rtl/rob_commit.sv
// Reorder buffer: in-order allocation, tag-matched writeback, one registered
// commit per cycle, and a full flush when a mispredicting entry commits.
module rob_commit #(
    parameter int ROB_DEPTH = 16,
    parameter int PTR_W     = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                dispatch_valid,
    input  logic [rob_commit_pkg::PcLength:0]   dispatch_pc,
    input  logic [rob_commit_pkg::RdLength:0]   dispatch_rd,
    output logic                                full_out,
    input  logic                                wb_valid,
    input  logic [rob_commit_pkg::PcLength:0]   wb_pc,
    input  logic [rob_commit_pkg::DataLength:0] wb_data,
    input  logic                                wb_mispredict,
    input  logic [rob_commit_pkg::PcLength:0]   wb_target,
    output logic                                is_finish_to_rf,
    output logic [rob_commit_pkg::RdLength:0]   rd_to_rf,
    output logic [rob_commit_pkg::DataLength:0] data_to_rf,
    output logic [rob_commit_pkg::PcLength:0]   pc_to_rf,
    output logic                                is_exception_to_rf,
    output logic [rob_commit_pkg::PcLength:0]   jump_pc_out
);
    import rob_commit_pkg::*;

    localparam logic [PTR_W:0] CountFull = (PTR_W+1)'(ROB_DEPTH);
    localparam logic [PTR_W:0] CountOne  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PtrOne  = PTR_W'(1);

    logic [ROB_DEPTH-1:0]  busy_q, ready_q, mis_q, wb_hit;
    logic [PcLength:0]     pc_q     [ROB_DEPTH];
    logic [RdLength:0]     rd_q     [ROB_DEPTH];
    logic [DataLength:0]   data_q   [ROB_DEPTH];
    logic [PcLength:0]     target_q [ROB_DEPTH];

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             full_q, full_d;

    logic                finish_q, exception_q;
    logic [RdLength:0]   rd_out_q;
    logic [DataLength:0] data_out_q;
    logic [PcLength:0]   pc_out_q, jump_q;

    logic commit_fire, flush, dispatch_fire, wb_fire;

    // Commit is decided purely from registered state, so a writeback always
    // costs one cycle before the entry can retire.
    assign commit_fire   = busy_q[head_q] && ready_q[head_q];
    assign flush         = commit_fire && mis_q[head_q];
    assign dispatch_fire = dispatch_valid && !full_q && !flush;
    assign wb_fire       = wb_valid && !flush;

    rob_tag_match #(
        .DEPTH (ROB_DEPTH)
    ) u_tag_match (
        .busy_i  (busy_q),
        .pc_i    (pc_q),
        .wb_pc_i (wb_pc),
        .hit_o   (wb_hit)
    );

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves
        // it unassigned, which would otherwise infer a latch.
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (dispatch_fire) tail_d = tail_q + PtrOne;
            if (commit_fire)   head_d = head_q + PtrOne;
            unique case ({dispatch_fire, commit_fire})
                2'b10:   count_d = count_q + CountOne;
                2'b01:   count_d = count_q - CountOne;
                default: count_d = count_q;
            endcase
        end
        full_d = (count_d == CountFull);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            full_q  <= False;
            busy_q  <= '0;
            ready_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            full_q  <= full_d;
            if (flush) begin
                busy_q  <= '0;
                ready_q <= '0;
            end else begin
                if (commit_fire) busy_q[head_q] <= False;
                if (wb_fire) begin
                    for (int i = 0; i < ROB_DEPTH; i++) begin
                        if (wb_hit[i]) ready_q[i] <= True;
                    end
                end
                if (dispatch_fire) begin
                    busy_q[tail_q]  <= True;
                    ready_q[tail_q] <= False;
                end
            end
        end
    end

    // NOTE: the payload arrays carry no reset; an entry's fields are only
    // read while its busy bit is set, and busy is always reset.
    always_ff @(posedge clk) begin
        if (wb_fire) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                if (wb_hit[i]) begin
                    data_q[i]   <= wb_data;
                    mis_q[i]    <= wb_mispredict;
                    target_q[i] <= wb_target;
                end
            end
        end
        if (dispatch_fire) begin
            pc_q[tail_q]  <= dispatch_pc;
            rd_q[tail_q]  <= dispatch_rd;
            mis_q[tail_q] <= False;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            finish_q    <= False;
            exception_q <= False;
            rd_out_q    <= '0;
            data_out_q  <= '0;
            pc_out_q    <= Zero;
            jump_q      <= Zero;
        end else begin
            finish_q    <= commit_fire;
            exception_q <= flush;
            if (commit_fire) begin
                rd_out_q   <= rd_q[head_q];
                data_out_q <= data_q[head_q];
                pc_out_q   <= pc_q[head_q];
            end
            if (flush) jump_q <= target_q[head_q];
        end
    end

    assign full_out           = full_q;
    assign is_finish_to_rf    = finish_q;
    assign is_exception_to_rf = exception_q;
    assign rd_to_rf           = rd_out_q;
    assign data_to_rf         = data_out_q;
    assign pc_to_rf           = pc_out_q;
    assign jump_pc_out        = jump_q;

endmodule

// File: doc/rob_commit.md
ROB_COMMIT -- requirements
Module: rob_commit

Interface
REQ-001 SHALL have parameters: ROB_DEPTH, default 16, entry count (power of 2); PTR_W, default 4, log2(ROB_DEPTH).
REQ-002 SHALL have ports: clk  in  1  clock, rising edge active.
REQ-003 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: dispatch_valid  in  1  new instruction offered for allocation.
REQ-005 SHALL have ports: dispatch_pc  in  32  instruction PC, also its tag; 0 = "no tag", never dispatched.
REQ-006 SHALL have ports: dispatch_rd  in  5  destination register; 0 = no architectural write.
REQ-007 SHALL have ports: full_out  out  1  registered; high when count == ROB_DEPTH.
REQ-008 SHALL have ports: wb_valid  in  1  result broadcast.
REQ-009 SHALL have ports: wb_pc  in  32  tag of producing instruction.
REQ-010 SHALL have ports: wb_data  in  32  result value.
REQ-011 SHALL have ports: wb_mispredict  in  1  control-flow redirect required at commit.
REQ-012 SHALL have ports: wb_target  in  32  redirect PC, valid with wb_mispredict.
REQ-013 SHALL have ports: is_finish_to_rf  out  1  one-cycle commit strobe.
REQ-014 SHALL have ports: rd_to_rf / data_to_rf / pc_to_rf  out  5/32/32  committed rd, value, tag.
REQ-015 SHALL have ports: is_exception_to_rf  out  1  one-cycle flush strobe, coincident with the mispredicting commit.
REQ-016 SHALL have ports: jump_pc_out  out  32  redirect target, valid with is_exception_to_rf.

Function
REQ-017 SHALL be a circular buffer: head (oldest), tail (next free), count; pointers wrap modulo ROB_DEPTH.
REQ-018 Entry fields SHALL be: busy, ready, pc, rd, data, mispredict, target.
REQ-019 Dispatch SHALL allocate at tail when dispatch_valid && !full_out: busy=1, ready=0, mispredict=0; tail+1.
REQ-020 Dispatch while full_out SHALL be dropped without state change; upstream holds the instruction.
REQ-021 full_out SHALL reflect count after the current edge; a same-cycle commit SHALL NOT unblock a same-cycle dispatch.
REQ-022 Writeback SHALL CAM-match wb_pc against all busy entries; the match sets ready=1, data, mispredict, target.
REQ-023 A writeback matching no busy entry SHALL be ignored.
REQ-024 Commit SHALL occur when head entry busy && ready (registered state), at most one per cycle, in program order.
REQ-025 Commit outputs SHALL be registered: strobe plus rd/data/pc one cycle after the edge where ready is observed; head+1, count-1.
REQ-026 An rd==0 commit SHALL still strobe is_finish_to_rf with rd_to_rf=0.
REQ-027 Minimum latency: dispatch edge N, writeback edge N+1, commit outputs valid after edge N+2.
REQ-028 A mispredicting head commit SHALL assert is_finish_to_rf and is_exception_to_rf together, drive jump_pc_out=target, and clear all busy bits, head=tail=0, count=0.
REQ-029 Dispatch and writeback in the flush cycle SHALL be discarded.
REQ-030 Simultaneous dispatch and commit SHALL update count by net zero.
REQ-031 Writeback to the entry allocated in the same cycle SHALL NOT match; the tag is not yet busy.
REQ-032 Output strobes SHALL be low in all cycles without a commit; data outputs hold their last value.

Reset
REQ-033 rst SHALL asynchronously clear all busy/ready bits, head, tail, count, and all outputs (strobes 0, buses 0, full_out 0).
REQ-034 Reset mid-operation SHALL discard all in-flight entries with no commit strobe emitted.
REQ-035 Operation SHALL resume on the first rising clk edge after rst deasserts.

Structure
REQ-036 Shared parameters package SHALL hold PcLength(31), DataLength(31), RdLength(4), Zero, True/False, ROB_DEPTH.
REQ-037 The CAM match SHALL be one sub-module, rob_tag_match: busy vector plus pc array plus wb_pc in, one-hot hit out.
REQ-038 No other sub-modules SHALL be used.

Verification
REQ-039 Dispatch pc=0x100 rd=5; wb pc=0x100 data=0xDEAD -> strobe with rd=5, data=0xDEAD, pc=0x100 exactly 2 cycles after dispatch.
REQ-040 Dispatch 0x100, 0x104; writeback 0x104 then 0x100 -> commits in order 0x100 then 0x104, on consecutive cycles.
REQ-041 Dispatch 16 entries -> full_out=1; the 17th is dropped; with the head committing in the same cycle as a dispatch, that dispatch is still dropped and is accepted the next cycle.
REQ-042 Three entries; middle writes back with mispredict, target 0x200 -> head commits normally, then the middle commits with is_exception_to_rf=1 and jump_pc_out=0x200; the third never commits; count=0.
REQ-043 Fill, wrap tail past index 15, and drain 20 instructions -> all 20 commit in order with correct data.
REQ-044 Assert rst with 5 entries pending -> all outputs 0 immediately; no strobes afterward; a fresh dispatch commits normally.
